// File: rtl/updown_counter_bank_if.sv
// Bus for updown_counter_bank: shared Initial/Limit, per-channel controls, packed
// counter values and wrap pulses.
interface updown_counter_bank_if #(
    parameter int SIZE     = 16,
    parameter int CHANNELS = 4
);
    logic [SIZE-1:0]          Initial;
    logic [SIZE-1:0]          Limit;
    logic [CHANNELS-1:0]      Load;
    logic [CHANNELS-1:0]      Enable;
    logic [CHANNELS-1:0]      Down;
    logic [CHANNELS*SIZE-1:0] Q;
    logic [CHANNELS-1:0]      Wrap;

    modport master (output Initial, Limit, Load, Enable, Down, input Q, Wrap);
    modport slave  (input Initial, Limit, Load, Enable, Down, output Q, Wrap);
endinterface

// File: rtl/updown_counter_bank.sv
// Bank of CHANNELS up/down modulo counters sharing Initial and Limit.
// Define COUNTER_SATURATE_EN to make every channel saturate instead of wrap.
module updown_counter_lane #(
    parameter int SIZE = 16
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic [SIZE-1:0] init_val,
    input  logic [SIZE-1:0] limit,
    input  logic            load,
    input  logic            enable,
    input  logic            down,
    output logic [SIZE-1:0] q,
    output logic            wrap
);
    logic at_top;
    logic at_bottom;
    logic above;

    // Out-of-range values (Initial above Limit, or Limit lowered) count as boundary hits
    assign at_top    = (q >= limit);
    assign at_bottom = (q == '0);
    assign above     = (q > limit);

    always_ff @(posedge Clock) begin
        if (Reset || load) begin
            q    <= init_val;
            wrap <= 1'b0;
        end else if (enable) begin
            if (!down) begin
                if (at_top) begin
`ifdef COUNTER_SATURATE_EN
                    q    <= limit;
`else
                    q    <= '0;
`endif
                    wrap <= 1'b1;
                end else begin
                    q    <= q + 1'b1;
                    wrap <= 1'b0;
                end
            end else begin
                if (above) begin
                    q    <= limit;
                    wrap <= 1'b1;
                end else if (at_bottom) begin
`ifdef COUNTER_SATURATE_EN
                    q    <= '0;
`else
                    q    <= limit;
`endif
                    wrap <= 1'b1;
                end else begin
                    q    <= q - 1'b1;
                    wrap <= 1'b0;
                end
            end
        end else begin
            wrap <= 1'b0;
        end
    end
endmodule

module updown_counter_bank #(
    parameter int SIZE     = 16,
    parameter int CHANNELS = 4
) (
    input logic                  Clock,
    input logic                  Reset,
    updown_counter_bank_if.slave bus
);
    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        updown_counter_lane #(.SIZE(SIZE)) u_lane (
            .Clock    (Clock),
            .Reset    (Reset),
            .init_val (bus.Initial),
            .limit    (bus.Limit),
            .load     (bus.Load[i]),
            .enable   (bus.Enable[i]),
            .down     (bus.Down[i]),
            .q        (bus.Q[i*SIZE +: SIZE]),
            .wrap     (bus.Wrap[i])
        );
    end
endmodule

// File: tb/tb_updown_counter_bank.sv
// Directed and random stimulus for updown_counter_bank, checked every cycle against
// a spec-level model plus hand-computed literal expectations.
module tb_updown_counter_bank;
    localparam int SIZE = 4;
    localparam int CH   = 4;

    logic Clock = 1'b0;
    logic Reset;
    updown_counter_bank_if #(.SIZE(SIZE), .CHANNELS(CH)) bus ();

    updown_counter_bank #(.SIZE(SIZE), .CHANNELS(CH)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 Clock = ~Clock;

    int checks   = 0;
    int failures = 0;
    int mq [CH];
    int mw [CH];
    logic chk_en = 1'b0;
    logic lit_en = 1'b0;
    logic [CH*SIZE-1:0] lit_q;
    logic [CH-1:0]      lit_w;

    // Spec-level reference: values as plain integers in range 0..2^SIZE-1
    task automatic model_step();
        int lim, ini;
        lim = int'(bus.Limit);
        ini = int'(bus.Initial);
        for (int i = 0; i < CH; i++) begin
            if (Reset || bus.Load[i]) begin
                mq[i] = ini; mw[i] = 0;
            end else if (!bus.Enable[i]) begin
                mw[i] = 0;
            end else if (!bus.Down[i]) begin
                if (mq[i] >= lim) begin
`ifdef COUNTER_SATURATE_EN
                    mq[i] = lim;
`else
                    mq[i] = 0;
`endif
                    mw[i] = 1;
                end else begin
                    mq[i] = mq[i] + 1; mw[i] = 0;
                end
            end else begin
                if (mq[i] > lim) begin
                    mq[i] = lim; mw[i] = 1;
                end else if (mq[i] == 0) begin
`ifdef COUNTER_SATURATE_EN
                    mq[i] = 0;
`else
                    mq[i] = lim;
`endif
                    mw[i] = 1;
                end else begin
                    mq[i] = mq[i] - 1; mw[i] = 0;
                end
            end
        end
    endtask

    always @(negedge Clock) begin
        if (chk_en) begin
            for (int i = 0; i < CH; i++) begin
                checks++;
                if (int'(bus.Q[i*SIZE +: SIZE]) != mq[i] || int'(bus.Wrap[i]) != mw[i]) begin
                    failures++;
                    $display("FAIL model ch%0d t=%0t: got Q=%0d Wrap=%0d, want Q=%0d Wrap=%0d",
                             i, $time, bus.Q[i*SIZE +: SIZE], bus.Wrap[i], mq[i], mw[i]);
                end
            end
            if (lit_en) begin
                checks++;
                if (bus.Q !== lit_q || bus.Wrap !== lit_w) begin
                    failures++;
                    $display("FAIL literal t=%0t: got Q=%h Wrap=%b, want Q=%h Wrap=%b",
                             $time, bus.Q, bus.Wrap, lit_q, lit_w);
                end
            end
        end
    end

    task automatic cyc();
        model_step();
        @(posedge Clock);
        chk_en = 1'b1;
        @(negedge Clock);
        #1;
        lit_en = 1'b0;
    endtask

    task automatic cyc_exp(input logic [CH*SIZE-1:0] q, input logic [CH-1:0] w);
        lit_q  = q;
        lit_w  = w;
        lit_en = 1'b1;
        cyc();
    endtask

    task automatic drive(input logic rst, input logic [3:0] ld, input logic [3:0] en,
                         input logic [3:0] dn);
        Reset      = rst;
        bus.Load   = ld;
        bus.Enable = en;
        bus.Down   = dn;
    endtask

    initial begin
        for (int i = 0; i < CH; i++) begin mq[i] = 0; mw[i] = 0; end
        bus.Initial = 4'd5;
        bus.Limit   = 4'd9;
        drive(1'b1, 4'h0, 4'h0, 4'h0);
        @(negedge Clock);

        // Reset state, then hold
        cyc_exp(16'h5555, 4'h0);
        drive(1'b0, 4'h0, 4'h0, 4'h0);
        cyc_exp(16'h5555, 4'h0);

        // Count ch0 up from 0 through the Limit=9 wrap
        bus.Initial = 4'd0;
        drive(1'b0, 4'hf, 4'h0, 4'h0);
        cyc_exp(16'h0000, 4'h0);
        drive(1'b0, 4'h0, 4'h1, 4'h0);
        for (int k = 1; k <= 8; k++) cyc();
        cyc_exp(16'h0009, 4'h0);
        cyc_exp(16'h0000, 4'h1);

        // ch1 counting down from 0
        drive(1'b0, 4'h0, 4'h2, 4'h2);
`ifdef COUNTER_SATURATE_EN
        cyc_exp(16'h0000, 4'h2);
        cyc_exp(16'h0000, 4'h2);
        cyc_exp(16'h0000, 4'h2);
`else
        cyc_exp(16'h0090, 4'h2);
        cyc_exp(16'h0080, 4'h0);
        cyc_exp(16'h0070, 4'h0);
`endif

        // Load beats Enable; Initial above Limit recovers on the next enable
        bus.Initial = 4'd12;
        drive(1'b0, 4'h4, 4'h4, 4'h0);
`ifdef COUNTER_SATURATE_EN
        cyc_exp(16'h0c00, 4'h0);
        drive(1'b0, 4'h0, 4'h4, 4'h0);
        cyc_exp(16'h0900, 4'h4);
`else
        cyc_exp(16'h0c70, 4'h0);
        drive(1'b0, 4'h0, 4'h4, 4'h0);
        cyc_exp(16'h0070, 4'h4);
`endif
        drive(1'b0, 4'h4, 4'h0, 4'h0);
        cyc();
        drive(1'b0, 4'h0, 4'h4, 4'h4);
`ifdef COUNTER_SATURATE_EN
        cyc_exp(16'h0900, 4'h4);
`else
        cyc_exp(16'h0970, 4'h4);
`endif

        // Limit=0, all enabled with mixed directions, then reset mid-stream
        bus.Limit = 4'd0;
        drive(1'b0, 4'h0, 4'hf, 4'h5);
        cyc_exp(16'h0000, 4'hf);
        cyc_exp(16'h0000, 4'hf);
        drive(1'b0, 4'h0, 4'hf, 4'ha);
        cyc_exp(16'h0000, 4'hf);
        bus.Initial = 4'd3;
        drive(1'b1, 4'h5, 4'hf, 4'ha);
        cyc_exp(16'h3333, 4'h0);

        // Random traffic, including Limit changes and all-ones Limit
        bus.Limit = 4'd15;
        for (int n = 0; n < 3000; n++) begin
            Reset = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < CH; i++) begin
                bus.Load[i]   = ($urandom_range(0, 9) == 0);
                bus.Enable[i] = ($urandom_range(0, 3) != 0);
                bus.Down[i]   = $urandom_range(0, 1) != 0;
            end
            if ($urandom_range(0, 15) == 0) bus.Limit   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0)  bus.Initial = 4'($urandom_range(0, 15));
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
